// File: rtl/gmii_pkg.sv
// Shared GMII receive constants, defaults and the deframer state encoding.
package gmii_pkg;

   localparam logic [7:0] GMII_PRE = 8'h55;
   localparam logic [7:0] GMII_SFD = 8'hD5;

   localparam int unsigned GMII_MIN_LEN = 14;
   localparam int unsigned GMII_MAX_LEN = 1522;

   // Preamble counter width; the count saturates at its all-ones value.
   localparam int unsigned GMII_PRE_CNT_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PRE  = 2'd1,
      ST_DATA = 2'd2,
      ST_DROP = 2'd3
   } rx_state_t;

endpackage : gmii_pkg

// File: rtl/gmii_rx_deframer.sv
// GMII receive deframer: strips preamble/SFD, marks SOF/EOF, reports length
// and malformed frames, and pulses on SFD for timestamp capture.
module gmii_rx_deframer
   import gmii_pkg::*;
#(
   parameter int unsigned MIN_PRE = 3,
   parameter int unsigned MIN_LEN = GMII_MIN_LEN,
   parameter int unsigned MAX_LEN = GMII_MAX_LEN,
   parameter int unsigned LEN_W   = 16
) (
   input  logic             gmii_clk,
   input  logic             rst_n,
   input  logic             gmii_ctrl,
   input  logic [7:0]       gmii_data,
   output logic             sfd_pulse,
   output logic             frm_valid,
   output logic [7:0]       frm_data,
   output logic             frm_sof,
   output logic             frm_eof,
   output logic [LEN_W-1:0] frm_len,
   output logic             frm_err
);

   localparam int unsigned PRE_W = GMII_PRE_CNT_W;
   localparam logic [PRE_W-1:0] PRE_SAT = '1;

   rx_state_t        state_q, state_d;
   logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
   logic [LEN_W-1:0] len_cnt_q, len_cnt_d;
   logic [7:0]       hold_q, hold_d;
   logic             sfd_pend_q, sfd_pend_d;

   logic             sfd_pulse_d;
   logic             frm_valid_d;
   logic [7:0]       frm_data_d;
   logic             frm_sof_d;
   logic             frm_eof_d;
   logic [LEN_W-1:0] frm_len_d;
   logic             frm_err_d;

   // State, counters, hold buffer and registered outputs.
   always_ff @(posedge gmii_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         pre_cnt_q  <= '0;
         len_cnt_q  <= '0;
         hold_q     <= '0;
         sfd_pend_q <= 1'b0;
         sfd_pulse  <= 1'b0;
         frm_valid  <= 1'b0;
         frm_data   <= '0;
         frm_sof    <= 1'b0;
         frm_eof    <= 1'b0;
         frm_len    <= '0;
         frm_err    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pre_cnt_q  <= pre_cnt_d;
         len_cnt_q  <= len_cnt_d;
         hold_q     <= hold_d;
         sfd_pend_q <= sfd_pend_d;
         sfd_pulse  <= sfd_pulse_d;
         frm_valid  <= frm_valid_d;
         frm_data   <= frm_data_d;
         frm_sof    <= frm_sof_d;
         frm_eof    <= frm_eof_d;
         frm_len    <= frm_len_d;
         frm_err    <= frm_err_d;
      end
   end

   // Next-state and next-output decode. The SFD pulse is delayed one extra
   // cycle through sfd_pend so it lands one cycle before the first frame byte.
   // A held byte exists whenever len_cnt_q is non-zero; it is the first
   // byte of the frame when len_cnt_q is one.
   always_comb begin
      state_d     = state_q;
      pre_cnt_d   = pre_cnt_q;
      len_cnt_d   = len_cnt_q;
      hold_d      = hold_q;
      sfd_pend_d  = 1'b0;
      sfd_pulse_d = sfd_pend_q;
      frm_valid_d = 1'b0;
      frm_data_d  = frm_data;
      frm_sof_d   = 1'b0;
      frm_eof_d   = 1'b0;
      frm_len_d   = frm_len;
      frm_err_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (gmii_ctrl) begin
               if (gmii_data == GMII_PRE) begin
                  state_d   = ST_PRE;
                  pre_cnt_d = PRE_W'(1);
               end else begin
                  state_d = ST_DROP;
               end
            end
         end

         ST_PRE: begin
            if (!gmii_ctrl) begin
               state_d = ST_IDLE;
            end else if (gmii_data == GMII_PRE) begin
               if (pre_cnt_q != PRE_SAT) begin
                  pre_cnt_d = pre_cnt_q + PRE_W'(1);
               end
            end else if ((gmii_data == GMII_SFD) && (32'(pre_cnt_q) >= MIN_PRE)) begin
               state_d    = ST_DATA;
               sfd_pend_d = 1'b1;
               len_cnt_d  = '0;
            end else begin
               state_d   = ST_DROP;
               frm_err_d = 1'b1;
            end
         end

         ST_DATA: begin
            if (gmii_ctrl) begin
               if (len_cnt_q == LEN_W'(MAX_LEN)) begin
                  // Oversize: close the frame on the last accepted byte.
                  frm_valid_d = 1'b1;
                  frm_data_d  = hold_q;
                  frm_sof_d   = (len_cnt_q == LEN_W'(1));
                  frm_eof_d   = 1'b1;
                  frm_err_d   = 1'b1;
                  frm_len_d   = LEN_W'(MAX_LEN);
                  state_d     = ST_DROP;
               end else begin
                  hold_d    = gmii_data;
                  len_cnt_d = len_cnt_q + LEN_W'(1);
                  if (len_cnt_q != '0) begin
                     frm_valid_d = 1'b1;
                     frm_data_d  = hold_q;
                     frm_sof_d   = (len_cnt_q == LEN_W'(1));
                  end
               end
            end else begin
               if (len_cnt_q != '0) begin
                  frm_valid_d = 1'b1;
                  frm_data_d  = hold_q;
                  frm_sof_d   = (len_cnt_q == LEN_W'(1));
                  frm_eof_d   = 1'b1;
                  frm_len_d   = len_cnt_q;
                  frm_err_d   = (len_cnt_q < LEN_W'(MIN_LEN));
               end else begin
                  // SFD followed directly by end of carrier.
                  frm_err_d = 1'b1;
               end
               state_d = ST_IDLE;
            end
         end

         ST_DROP: begin
            if (!gmii_ctrl) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule : gmii_rx_deframer

// File: tb/tb_gmii_rx_deframer.sv
// Directed self-checking bench for gmii_rx_deframer (instance built with MAX_LEN=64).
module tb_gmii_rx_deframer;

   localparam int unsigned LEN_W = 16;

   logic             gmii_clk;
   logic             rst_n;
   logic             gmii_ctrl;
   logic [7:0]       gmii_data;
   logic             sfd_pulse;
   logic             frm_valid;
   logic [7:0]       frm_data;
   logic             frm_sof;
   logic             frm_eof;
   logic [LEN_W-1:0] frm_len;
   logic             frm_err;

   gmii_rx_deframer #(
      .MIN_PRE (3),
      .MIN_LEN (14),
      .MAX_LEN (64),
      .LEN_W   (LEN_W)
   ) dut (
      .gmii_clk  (gmii_clk),
      .rst_n     (rst_n),
      .gmii_ctrl (gmii_ctrl),
      .gmii_data (gmii_data),
      .sfd_pulse (sfd_pulse),
      .frm_valid (frm_valid),
      .frm_data  (frm_data),
      .frm_sof   (frm_sof),
      .frm_eof   (frm_eof),
      .frm_len   (frm_len),
      .frm_err   (frm_err)
   );

   initial gmii_clk = 1'b0;
   always #4 gmii_clk = ~gmii_clk;

   int checks = 0;
   int errors = 0;

   // Per-segment observation counters.
   int cyc_n = 0;
   int n_sfd, n_errp, n_valid, n_sof, n_eof, n_sofeof, data_bad, len_sum;
   int sfd_cyc, first_cyc;
   int sof_data, eof_data, eof_err;
   logic [7:0] exp_q[$];

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clr();
      n_sfd = 0; n_errp = 0; n_valid = 0; n_sof = 0; n_eof = 0; n_sofeof = 0;
      data_bad = 0; len_sum = 0; sfd_cyc = -1; first_cyc = -1;
      sof_data = -1; eof_data = -1; eof_err = -1;
      exp_q.delete();
   endtask

   // One clock: drive, take the edge, then observe the registered outputs.
   task automatic cyc(input logic c, input logic [7:0] d);
      logic [7:0] exp_b;
      gmii_ctrl = c;
      gmii_data = d;
      @(posedge gmii_clk);
      #1;
      cyc_n++;
      if (sfd_pulse) begin n_sfd++; sfd_cyc = cyc_n; end
      if (frm_err) n_errp++;
      if (frm_valid) begin
         if (n_valid == 0) first_cyc = cyc_n;
         n_valid++;
         if (exp_q.size() == 0) data_bad++;
         else begin
            exp_b = exp_q.pop_front();
            if (frm_data !== exp_b) data_bad++;
         end
         if (frm_sof) begin n_sof++; sof_data = int'(frm_data); end
         if (frm_eof) begin
            n_eof++;
            eof_data = int'(frm_data);
            eof_err = int'(frm_err);
            len_sum += int'(frm_len);
            if (frm_sof) n_sofeof++;
         end
      end
   endtask

   task automatic send_frame(input int npre, input int nbytes, input logic [7:0] start, input int nidle);
      logic [7:0] b;
      for (int i = 0; i < npre; i++) cyc(1'b1, 8'h55);
      cyc(1'b1, 8'hD5);
      for (int i = 0; i < nbytes; i++) begin
         b = 8'(int'(start) + i);
         exp_q.push_back(b);
         cyc(1'b1, b);
      end
      for (int i = 0; i < nidle; i++) cyc(1'b0, 8'h00);
   endtask

   initial begin
      rst_n = 1'b0;
      gmii_ctrl = 1'b0;
      gmii_data = 8'h00;
      clr();
      #20;
      chk("rst_sfd_pulse", int'(sfd_pulse), 0);
      chk("rst_frm_valid", int'(frm_valid), 0);
      chk("rst_frm_data", int'(frm_data), 0);
      chk("rst_frm_sof", int'(frm_sof), 0);
      chk("rst_frm_eof", int'(frm_eof), 0);
      chk("rst_frm_len", int'(frm_len), 0);
      chk("rst_frm_err", int'(frm_err), 0);
      @(negedge gmii_clk);
      rst_n = 1'b1;

      // Basic 60-byte frame after 12 idle cycles.
      clr();
      for (int i = 0; i < 12; i++) cyc(1'b0, 8'h00);
      send_frame(3, 60, 8'h00, 3);
      chk("t1_sfd_cnt", n_sfd, 1);
      chk("t1_sfd_to_first", first_cyc - sfd_cyc, 1);
      chk("t1_beats", n_valid, 60);
      chk("t1_sof_cnt", n_sof, 1);
      chk("t1_sof_data", sof_data, 'h00);
      chk("t1_eof_cnt", n_eof, 1);
      chk("t1_eof_data", eof_data, 'h3B);
      chk("t1_len", len_sum, 60);
      chk("t1_err", n_errp, 0);
      chk("t1_data", data_bad, 0);
      chk("t1_len_held", int'(frm_len), 60);
      chk("t1_data_held", int'(frm_data), 'h3B);

      // SFD then immediate end of carrier.
      clr();
      send_frame(3, 0, 8'h00, 2);
      chk("zl_sfd_cnt", n_sfd, 1);
      chk("zl_err", n_errp, 1);
      chk("zl_beats", n_valid, 0);
      chk("zl_len_kept", int'(frm_len), 60);

      // Back-to-back 64-byte frames with one idle cycle; 64 equals MAX_LEN.
      clr();
      send_frame(7, 64, 8'h40, 1);
      send_frame(7, 64, 8'h40, 2);
      chk("t2_sfd_cnt", n_sfd, 2);
      chk("t2_beats", n_valid, 128);
      chk("t2_sof_cnt", n_sof, 2);
      chk("t2_eof_cnt", n_eof, 2);
      chk("t2_len_sum", len_sum, 128);
      chk("t2_len", int'(frm_len), 64);
      chk("t2_eof_data", eof_data, 'h7F);
      chk("t2_err", n_errp, 0);
      chk("t2_data", data_bad, 0);

      // Short preamble: error pulse, frame dropped.
      clr();
      send_frame(2, 20, 8'hA0, 2);
      chk("t3_err", n_errp, 1);
      chk("t3_beats", n_valid, 0);
      chk("t3_sfd_cnt", n_sfd, 0);
      chk("t3_len_kept", int'(frm_len), 64);

      // Runt frame of 10 bytes.
      clr();
      send_frame(3, 10, 8'hC0, 2);
      chk("t4_beats", n_valid, 10);
      chk("t4_eof_cnt", n_eof, 1);
      chk("t4_eof_err", eof_err, 1);
      chk("t4_len", len_sum, 10);
      chk("t4_data", data_bad, 0);

      // One-byte frame: SOF and EOF on the same beat.
      clr();
      send_frame(3, 1, 8'h99, 2);
      chk("t1b_beats", n_valid, 1);
      chk("t1b_sofeof", n_sofeof, 1);
      chk("t1b_eof_err", eof_err, 1);
      chk("t1b_len", int'(frm_len), 1);

      // Oversize 70-byte frame, then a clean 20-byte frame.
      clr();
      send_frame(3, 70, 8'h10, 2);
      chk("t5_beats", n_valid, 64);
      chk("t5_eof_cnt", n_eof, 1);
      chk("t5_eof_err", eof_err, 1);
      chk("t5_eof_data", eof_data, 'h4F);
      chk("t5_len", int'(frm_len), 64);
      chk("t5_err_cnt", n_errp, 1);
      chk("t5_data", data_bad, 0);
      clr();
      send_frame(3, 20, 8'h20, 2);
      chk("t5n_beats", n_valid, 20);
      chk("t5n_len", int'(frm_len), 20);
      chk("t5n_err", n_errp, 0);
      chk("t5n_data", data_bad, 0);

      // Reset during byte 30 of a 60-byte frame, then a clean 60-byte frame.
      clr();
      send_frame(3, 29, 8'h00, 0);
      chk("t6_pre_valid", int'(frm_valid), 1);
      gmii_ctrl = 1'b1;
      gmii_data = 8'h1D;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", int'(frm_valid), 0);
      chk("t6_rst_data", int'(frm_data), 0);
      chk("t6_rst_sof", int'(frm_sof), 0);
      chk("t6_rst_len", int'(frm_len), 0);
      chk("t6_eof_cnt", n_eof, 0);
      gmii_ctrl = 1'b0;
      gmii_data = 8'h00;
      repeat (2) @(negedge gmii_clk);
      rst_n = 1'b1;
      clr();
      send_frame(3, 60, 8'h80, 2);
      chk("t6n_beats", n_valid, 60);
      chk("t6n_sof_data", sof_data, 'h80);
      chk("t6n_eof_data", eof_data, 'hBB);
      chk("t6n_len", int'(frm_len), 60);
      chk("t6n_err", n_errp, 0);
      chk("t6n_data", data_bad, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_gmii_rx_deframer

// File: doc/gmii_rx_deframer.md
Name: gmii_rx_deframer

Overview:
- Synthesizable GMII receive-side deframer that consumes the byte stream produced onto the GMII link (idle, preamble 0x55, SFD 0xD5, frame bytes).
- Strips preamble and SFD, and emits frame bytes with start-of-frame and end-of-frame markers.
- Emits a one-cycle SFD pulse for timestamp capture by the TSU, and a frame length at end of frame.
- Flags malformed frames: bad or short preamble, runt, or oversize.

Parameters:
- MIN_PRE, 3, minimum count of consecutive 0x55 bytes required before 0xD5.
- MIN_LEN, 14, minimum frame byte count (after SFD); shorter frames are errored.
- MAX_LEN, 1522, maximum frame byte count; the byte that would exceed it triggers error and drop.
- LEN_W, 16, width of the length counter and frm_len.

Ports:
- gmii_clk  in  1  GMII byte clock, 125 MHz.
- rst_n  in  1  asynchronous active-low reset.
- gmii_ctrl  in  1  receive data valid (ctrl).
- gmii_data  in  8  receive byte.
- sfd_pulse  out  1  one-cycle pulse, registered, on the edge after the SFD byte is sampled.
- frm_valid  out  1  frm_data holds a frame byte this cycle.
- frm_data  out  8  frame byte (after SFD).
- frm_sof  out  1  with frm_valid: first frame byte.
- frm_eof  out  1  with frm_valid: last frame byte.
- frm_len  out  LEN_W  byte count of the frame; valid when frm_eof=1, held until the next eof.
- frm_err  out  1  with frm_eof, or as a standalone one-cycle pulse: frame malformed.

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0: sfd_pulse, frm_valid, frm_data, frm_sof, frm_eof, frm_len, frm_err.
  - State IDLE; pre_cnt=0; len_cnt=0; hold buffer empty.
- Inputs are sampled on rising gmii_clk only.
- State machine (IDLE, PRE, DATA, DROP):
  - IDLE:
    - ctrl=1 and data=0x55 -> PRE, pre_cnt=1.
    - ctrl=1 and any other data -> DROP.
  - PRE:
    - ctrl=1, 0x55 -> pre_cnt++ (saturates at 7).
    - ctrl=1, 0xD5, pre_cnt>=MIN_PRE -> DATA; sfd_pulse=1 next cycle.
    - ctrl=1, 0xD5 with pre_cnt<MIN_PRE, or any other byte -> DROP with frm_err pulse (frm_valid=0).
    - ctrl=0 -> IDLE, no error.
  - DATA:
    - Each ctrl=1 byte is loaded into a one-byte hold buffer; len_cnt++.
    - The previous held byte is output on the same edge with frm_valid=1 and frm_eof=0.
    - frm_sof=1 on the first output byte of a frame.
  - DATA, ctrl=0:
    - The held byte is output with frm_eof=1 and frm_len=len_cnt.
    - frm_err=1 if len_cnt<MIN_LEN.
    - Next state IDLE.
  - DATA, len_cnt reaches MAX_LEN and another ctrl=1 byte arrives:
    - Output the held byte with frm_eof=1, frm_err=1, frm_len=MAX_LEN.
    - Next state DROP.
  - DROP: ignore everything until ctrl=0, then IDLE.
- Latency:
  - A frame byte sampled at edge k appears on frm_data after edge k+1.
  - sfd_pulse asserts after the edge following the SFD sample.
  - The first frame byte appears one cycle after sfd_pulse.
- SFD with ctrl dropping immediately (zero-length frame):
  - One-cycle frm_err pulse, frm_valid=0, frm_len unchanged, next state IDLE.
- One-byte frame: that byte carries frm_sof=1 and frm_eof=1 together (frm_err=1 when MIN_LEN>1).
- Back-to-back frames with one idle cycle (ctrl=0) are fully supported. No minimum IFG is enforced.
- frm_valid is never asserted outside DATA or its final eof cycle.
- frm_data retains its last value when frm_valid=0.
- Reset asserted mid-frame: the frame is discarded without an eof; all outputs drop to 0 immediately.
- len_cnt saturates; it cannot wrap, since MAX_LEN < 2^LEN_W. Instantiation requires MAX_LEN < 2^LEN_W.

Decomposition:
- Shared package gmii_pkg holds:
  - Constants GMII_PRE=8'h55 and GMII_SFD=8'hD5.
  - The state enumeration.
  - Default MIN_LEN and MAX_LEN.
- Single module, with no sub-module. The hold buffer and counters stay inline.

Test Plan:
- 12 idle, 3x0x55, 0xD5, 60 bytes 0x00..0x3B, ctrl low -> sfd_pulse one cycle; 60 frm_valid beats; sof on 0x00, eof on 0x3B; frm_len=60; frm_err=0.
- 7x0x55, 0xD5, 64 bytes, 1 idle cycle, then a second identical frame -> two clean frames; each frm_len=64; sof/eof correct; no lost beat.
- 2x0x55, 0xD5, 20 bytes -> one frm_err pulse; no frm_valid; no sfd_pulse.
- Preamble and SFD, then 10 bytes -> 10 beats; eof with frm_err=1, frm_len=10.
- MAX_LEN=64, 70-byte frame -> 64 beats; eof on beat 64 with frm_err=1, frm_len=64; remaining bytes ignored; the next frame is received cleanly.
- rst_n low during byte 30 of a 60-byte frame -> outputs 0 immediately; no eof; the following frame is received correctly with frm_len exact.
